// File: rtl/ecc_rx_buffer_if.sv
// Handshake bundle for the ECC receive buffer: the upstream word/status
// stream and the downstream valid/ready consumer port.
interface ecc_rx_buffer_if;
  logic        valid_in;
  logic [31:0] data_in;
  logic        error_detected;
  logic        error_corrected;
  logic        m_valid;
  logic        m_ready;
  logic [31:0] m_data;
  logic        m_corrected;
  logic        m_uncorr;

  // Buffer side
  modport slave (
    input  valid_in, data_in, error_detected, error_corrected, m_ready,
    output m_valid, m_data, m_corrected, m_uncorr
  );

  // Producer/consumer side
  modport master (
    output valid_in, data_in, error_detected, error_corrected, m_ready,
    input  m_valid, m_data, m_corrected, m_uncorr
  );
endinterface

// File: rtl/ecc_rx_buffer.sv
// ECC receive buffer: small FIFO of {data, corrected, uncorrectable} entries
// behind a valid/ready port, with saturating error/overflow statistics and a
// sticky interrupt. Upstream cannot be stalled, so a word arriving at a full
// FIFO (with no pop in the same cycle) is lost and counted.
module ecc_rx_buffer #(
  parameter int DEPTH       = 8,
  parameter int CNT_W       = 16,
  parameter int DROP_UNCORR = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  ecc_rx_buffer_if.slave           bus,
  input  logic                     clear_stats,
  output logic [$clog2(DEPTH):0]   fill_level,
  output logic [CNT_W-1:0]         corr_cnt,
  output logic [CNT_W-1:0]         uncorr_cnt,
  output logic [CNT_W-1:0]         ovf_cnt,
  output logic                     irq
);

  localparam int AW = $clog2(DEPTH);
  localparam int FW = AW + 1;
  localparam int EW = 34;
  localparam logic [FW-1:0]    FULL_LVL = FW'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic             DROP_EN  = (DROP_UNCORR != 0);

  // Clear-then-apply saturating counter step: an event in the clear cycle
  // leaves the counter at 1.
  function automatic logic [CNT_W-1:0] sat_next(
    input logic [CNT_W-1:0] cur,
    input logic             clr,
    input logic             ev
  );
    logic [CNT_W-1:0] base;
    base = clr ? {CNT_W{1'b0}} : cur;
    if (ev && (base != CNT_MAX)) begin
      sat_next = base + CNT_W'(1);
    end else begin
      sat_next = base;
    end
  endfunction

  logic [EW-1:0]    mem_q [DEPTH];
  logic [EW-1:0]    mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [FW-1:0]    fill_q, fill_d;
  logic [CNT_W-1:0] corr_cnt_q, corr_cnt_d;
  logic [CNT_W-1:0] uncorr_cnt_q, uncorr_cnt_d;
  logic [CNT_W-1:0] ovf_cnt_q, ovf_cnt_d;
  logic             irq_q, irq_d;

  logic             corr_s, uncorr_s, want_s, push_s, pop_s, ovf_s;
  logic             full_s, empty_s;
  logic [EW-1:0]    entry_s, head_s;

  // Event decode and push/pop/overflow qualification
  always_comb begin
    full_s   = (fill_q == FULL_LVL);
    empty_s  = (fill_q == {FW{1'b0}});
    corr_s   = bus.valid_in & bus.error_corrected;
    uncorr_s = bus.valid_in & bus.error_detected & ~bus.error_corrected;
    pop_s    = ~empty_s & bus.m_ready;
    want_s   = bus.valid_in & ~(DROP_EN & uncorr_s);
    push_s   = want_s & (~full_s | pop_s);
    ovf_s    = want_s & full_s & ~pop_s;
    entry_s  = {bus.data_in, corr_s, uncorr_s};
  end

  // Next-state for storage, pointers and occupancy
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_s) begin
      mem_d[wr_ptr_q] = entry_s;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_s, pop_s})
      2'b10:   fill_d = fill_q + FW'(1);
      2'b01:   fill_d = fill_q - FW'(1);
      default: fill_d = fill_q;
    endcase
  end

  // Next-state for statistics and sticky interrupt
  always_comb begin
    corr_cnt_d   = sat_next(corr_cnt_q,   clear_stats, corr_s);
    uncorr_cnt_d = sat_next(uncorr_cnt_q, clear_stats, uncorr_s);
    ovf_cnt_d    = sat_next(ovf_cnt_q,    clear_stats, ovf_s);
    irq_d        = (clear_stats ? 1'b0 : irq_q) | uncorr_s | ovf_s;
  end

  // State registers, flushed asynchronously by reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= {EW{1'b0}};
      end
      wr_ptr_q     <= {AW{1'b0}};
      rd_ptr_q     <= {AW{1'b0}};
      fill_q       <= {FW{1'b0}};
      corr_cnt_q   <= {CNT_W{1'b0}};
      uncorr_cnt_q <= {CNT_W{1'b0}};
      ovf_cnt_q    <= {CNT_W{1'b0}};
      irq_q        <= 1'b0;
    end else begin
      mem_q        <= mem_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      fill_q       <= fill_d;
      corr_cnt_q   <= corr_cnt_d;
      uncorr_cnt_q <= uncorr_cnt_d;
      ovf_cnt_q    <= ovf_cnt_d;
      irq_q        <= irq_d;
    end
  end

  // Head entry presented combinationally; zeroed when nothing is stored
  always_comb begin
    head_s = mem_q[rd_ptr_q];
    if (empty_s) begin
      bus.m_valid     = 1'b0;
      bus.m_data      = 32'h0000_0000;
      bus.m_corrected = 1'b0;
      bus.m_uncorr    = 1'b0;
    end else begin
      bus.m_valid     = 1'b1;
      bus.m_data      = head_s[33:2];
      bus.m_corrected = head_s[1];
      bus.m_uncorr    = head_s[0];
    end
  end

  assign fill_level = fill_q;
  assign corr_cnt   = corr_cnt_q;
  assign uncorr_cnt = uncorr_cnt_q;
  assign ovf_cnt    = ovf_cnt_q;
  assign irq        = irq_q;

endmodule

// File: tb/tb_ecc_rx_buffer.sv
// Directed bench for ecc_rx_buffer. Two instances share one stimulus:
// dut_a (DEPTH=8, CNT_W=16, DROP_UNCORR=1) and dut_b (DEPTH=8, CNT_W=4,
// DROP_UNCORR=0). Inputs change 1 time unit after a rising edge and outputs
// are sampled at that same point.
module tb_ecc_rx_buffer;

  logic        clk;
  logic        rst_n;
  logic        valid_in;
  logic [31:0] data_in;
  logic        ed;
  logic        ec;
  logic        m_ready;
  logic        clear_stats;

  logic [3:0]  fill_a, fill_b;
  logic [15:0] corr_a, uncorr_a, ovf_a;
  logic [3:0]  corr_b, uncorr_b, ovf_b;
  logic        irq_a, irq_b;

  int n_pass;
  int n_total;

  ecc_rx_buffer_if if_a ();
  ecc_rx_buffer_if if_b ();

  assign if_a.valid_in        = valid_in;
  assign if_a.data_in         = data_in;
  assign if_a.error_detected  = ed;
  assign if_a.error_corrected = ec;
  assign if_a.m_ready         = m_ready;
  assign if_b.valid_in        = valid_in;
  assign if_b.data_in         = data_in;
  assign if_b.error_detected  = ed;
  assign if_b.error_corrected = ec;
  assign if_b.m_ready         = m_ready;

  ecc_rx_buffer #(.DEPTH(8), .CNT_W(16), .DROP_UNCORR(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(if_a), .clear_stats(clear_stats),
    .fill_level(fill_a), .corr_cnt(corr_a), .uncorr_cnt(uncorr_a),
    .ovf_cnt(ovf_a), .irq(irq_a)
  );

  ecc_rx_buffer #(.DEPTH(8), .CNT_W(4), .DROP_UNCORR(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(if_b), .clear_stats(clear_stats),
    .fill_level(fill_b), .corr_cnt(corr_b), .uncorr_cnt(uncorr_b),
    .ovf_cnt(ovf_b), .irq(irq_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    valid_in    = 1'b0;
    data_in     = 32'h0;
    ed          = 1'b0;
    ec          = 1'b0;
    m_ready     = 1'b0;
    clear_stats = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    cycle();
    cycle();
    rst_n = 1'b1;
    cycle();
  endtask

  task automatic test_reset();
    do_reset();
    n_total++; if (if_a.m_valid !== 1'b0) $display("FAIL rst_m_valid: got %0b exp 0", if_a.m_valid); else n_pass++;
    n_total++; if (if_a.m_data !== 32'h0) $display("FAIL rst_m_data: got %h exp 0", if_a.m_data); else n_pass++;
    n_total++; if ({if_a.m_corrected, if_a.m_uncorr} !== 2'b00) $display("FAIL rst_m_flags: got %b exp 00", {if_a.m_corrected, if_a.m_uncorr}); else n_pass++;
    n_total++; if (fill_a !== 4'd0) $display("FAIL rst_fill: got %0d exp 0", fill_a); else n_pass++;
    n_total++; if ({corr_a, uncorr_a, ovf_a} !== 48'h0) $display("FAIL rst_cnts: got %h exp 0", {corr_a, uncorr_a, ovf_a}); else n_pass++;
    n_total++; if (irq_a !== 1'b0) $display("FAIL rst_irq: got %0b exp 0", irq_a); else n_pass++;
  endtask

  task automatic test_basic();
    logic [31:0] w [3];
    w[0] = 32'h1111_1111; w[1] = 32'h2222_2222; w[2] = 32'h3333_3333;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      valid_in = 1'b1; data_in = w[i];
      cycle();
    end
    valid_in = 1'b0;
    n_total++; if (fill_a !== 4'd3) $display("FAIL basic_fill: got %0d exp 3", fill_a); else n_pass++;
    n_total++; if (if_a.m_data !== 32'h1111_1111) $display("FAIL basic_head: got %h exp 11111111", if_a.m_data); else n_pass++;
    cycle();
    n_total++; if (if_a.m_data !== 32'h1111_1111) $display("FAIL basic_hold: got %h exp 11111111", if_a.m_data); else n_pass++;
    m_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      n_total++; if (if_a.m_valid !== 1'b1 || if_a.m_data !== w[i]) $display("FAIL basic_drain%0d: got v=%0b d=%h exp v=1 d=%h", i, if_a.m_valid, if_a.m_data, w[i]); else n_pass++;
      cycle();
    end
    n_total++; if (if_a.m_valid !== 1'b0) $display("FAIL basic_empty: got %0b exp 0", if_a.m_valid); else n_pass++;
    n_total++; if ({corr_a, uncorr_a, ovf_a, irq_a} !== 49'h0) $display("FAIL basic_cnts: got %h exp 0", {corr_a, uncorr_a, ovf_a, irq_a}); else n_pass++;
    m_ready = 1'b0;
  endtask

  task automatic test_overflow();
    do_reset();
    for (int i = 0; i < 10; i++) begin
      valid_in = 1'b1; data_in = 32'h100 + 32'(i);
      cycle();
    end
    valid_in = 1'b0;
    n_total++; if (fill_a !== 4'd8) $display("FAIL ovf_fill: got %0d exp 8", fill_a); else n_pass++;
    n_total++; if (ovf_a !== 16'd2) $display("FAIL ovf_cnt: got %0d exp 2", ovf_a); else n_pass++;
    n_total++; if (irq_a !== 1'b1) $display("FAIL ovf_irq: got %0b exp 1", irq_a); else n_pass++;
    m_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      n_total++; if (if_a.m_data !== 32'h100 + 32'(i)) $display("FAIL ovf_order%0d: got %h exp %h", i, if_a.m_data, 32'h100 + 32'(i)); else n_pass++;
      cycle();
    end
    n_total++; if (if_a.m_valid !== 1'b0) $display("FAIL ovf_drained: got %0b exp 0", if_a.m_valid); else n_pass++;
    // Same stream, but the consumer pops in the cycles where the FIFO is full
    do_reset();
    for (int i = 0; i < 10; i++) begin
      valid_in = 1'b1; data_in = 32'h200 + 32'(i);
      m_ready  = (i >= 8);
      cycle();
    end
    valid_in = 1'b0; m_ready = 1'b0;
    n_total++; if (fill_a !== 4'd8) $display("FAIL fullpop_fill: got %0d exp 8", fill_a); else n_pass++;
    n_total++; if (ovf_a !== 16'd0 || irq_a !== 1'b0) $display("FAIL fullpop_noovf: got ovf=%0d irq=%0b exp 0 0", ovf_a, irq_a); else n_pass++;
    m_ready = 1'b1;
    for (int i = 2; i < 10; i++) begin
      n_total++; if (if_a.m_data !== 32'h200 + 32'(i)) $display("FAIL fullpop_order%0d: got %h exp %h", i, if_a.m_data, 32'h200 + 32'(i)); else n_pass++;
      cycle();
    end
    m_ready = 1'b0;
  endtask

  task automatic test_ecc();
    do_reset();
    valid_in = 1'b1; data_in = 32'hDEAD_BEEF; ed = 1'b1; ec = 1'b1;
    cycle();
    n_total++; if (if_a.m_data !== 32'hDEAD_BEEF || if_a.m_corrected !== 1'b1 || if_a.m_uncorr !== 1'b0) $display("FAIL ecc_corr_entry: got d=%h c=%0b u=%0b exp deadbeef 1 0", if_a.m_data, if_a.m_corrected, if_a.m_uncorr); else n_pass++;
    n_total++; if (corr_a !== 16'd1 || irq_a !== 1'b0) $display("FAIL ecc_corr_stats: got cnt=%0d irq=%0b exp 1 0", corr_a, irq_a); else n_pass++;
    data_in = 32'hBAD0_BAD0; ed = 1'b1; ec = 1'b0;
    cycle();
    n_total++; if (fill_a !== 4'd1) $display("FAIL ecc_drop_fill: got %0d exp 1", fill_a); else n_pass++;
    n_total++; if (uncorr_a !== 16'd1 || irq_a !== 1'b1) $display("FAIL ecc_drop_stats: got cnt=%0d irq=%0b exp 1 1", uncorr_a, irq_a); else n_pass++;
    n_total++; if (fill_b !== 4'd2) $display("FAIL ecc_keep_fill: got %0d exp 2", fill_b); else n_pass++;
    valid_in = 1'b0; ed = 1'b0; m_ready = 1'b1;
    cycle();
    m_ready = 1'b0;
    n_total++; if (if_a.m_valid !== 1'b0) $display("FAIL ecc_drop_empty: got %0b exp 0", if_a.m_valid); else n_pass++;
    n_total++; if (if_b.m_data !== 32'hBAD0_BAD0 || if_b.m_uncorr !== 1'b1 || if_b.m_corrected !== 1'b0) $display("FAIL ecc_keep_entry: got d=%h c=%0b u=%0b exp bad0bad0 0 1", if_b.m_data, if_b.m_corrected, if_b.m_uncorr); else n_pass++;
  endtask

  task automatic test_saturation();
    do_reset();
    m_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      valid_in = 1'b1; data_in = 32'(i); ed = 1'b1; ec = 1'b1;
      cycle();
    end
    n_total++; if (corr_b !== 4'd15) $display("FAIL sat_hold: got %0d exp 15", corr_b); else n_pass++;
    n_total++; if (corr_a !== 16'd20) $display("FAIL sat_wide: got %0d exp 20", corr_a); else n_pass++;
    ec = 1'b0;
    cycle();
    n_total++; if (uncorr_b !== 4'd1 || irq_b !== 1'b1) $display("FAIL sat_pre_irq: got cnt=%0d irq=%0b exp 1 1", uncorr_b, irq_b); else n_pass++;
    clear_stats = 1'b1; ec = 1'b1;
    cycle();
    n_total++; if (corr_b !== 4'd1 || uncorr_b !== 4'd0 || irq_b !== 1'b0) $display("FAIL clr_corr: got c=%0d u=%0d irq=%0b exp 1 0 0", corr_b, uncorr_b, irq_b); else n_pass++;
    ec = 1'b0;
    cycle();
    n_total++; if (corr_b !== 4'd0 || uncorr_b !== 4'd1 || irq_b !== 1'b1) $display("FAIL clr_uncorr: got c=%0d u=%0d irq=%0b exp 0 1 1", corr_b, uncorr_b, irq_b); else n_pass++;
    idle_inputs();
    cycle();
  endtask

  task automatic test_async_reset();
    do_reset();
    for (int i = 0; i < 5; i++) begin
      valid_in = 1'b1; data_in = 32'h500 + 32'(i);
      cycle();
    end
    data_in = 32'h5FF; ed = 1'b1; ec = 1'b0;
    cycle();
    idle_inputs();
    n_total++; if (fill_a !== 4'd5 || irq_a !== 1'b1) $display("FAIL arst_pre: got fill=%0d irq=%0b exp 5 1", fill_a, irq_a); else n_pass++;
    #2 rst_n = 1'b0;
    #1;
    n_total++; if (fill_a !== 4'd0 || if_a.m_valid !== 1'b0 || irq_a !== 1'b0) $display("FAIL arst_flush: got fill=%0d v=%0b irq=%0b exp 0 0 0", fill_a, if_a.m_valid, irq_a); else n_pass++;
    rst_n = 1'b1;
    valid_in = 1'b1; data_in = 32'hCAFE_F00D;
    cycle();
    valid_in = 1'b0;
    n_total++; if (if_a.m_valid !== 1'b1 || if_a.m_data !== 32'hCAFE_F00D) $display("FAIL arst_first: got v=%0b d=%h exp 1 cafef00d", if_a.m_valid, if_a.m_data); else n_pass++;
  endtask

  task automatic test_idle_flags();
    do_reset();
    for (int i = 0; i < 10; i++) begin
      valid_in = 1'b0; ed = 1'b1; ec = i[0];
      cycle();
    end
    idle_inputs();
    n_total++; if (fill_a !== 4'd0 || if_a.m_valid !== 1'b0) $display("FAIL idle_nopush: got fill=%0d v=%0b exp 0 0", fill_a, if_a.m_valid); else n_pass++;
    n_total++; if ({corr_a, uncorr_a, ovf_a, irq_a} !== 49'h0) $display("FAIL idle_cnts: got %h exp 0", {corr_a, uncorr_a, ovf_a, irq_a}); else n_pass++;
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;
    rst_n   = 1'b0;
    idle_inputs();
    test_reset();
    test_basic();
    test_overflow();
    test_ecc();
    test_saturation();
    test_async_reset();
    test_idle_flags();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/ecc_rx_buffer.md
# ecc_rx_buffer

Receive-side buffer placed directly downstream of the high-speed bus interface stage. Captures each ECC-checked 32-bit word with its correction status into a small synchronous FIFO, and presents it to the consumer over a valid/ready handshake. Optionally discards uncorrectable words. Keeps saturating error and overflow statistics plus a sticky interrupt for software.

## Interface
- DEPTH, 8: FIFO entries. Must be a power of two and at least 2.
- CNT_W, 16: width of each statistics counter.
- DROP_UNCORR, 1: 1 = uncorrectable words are never written; 0 = they are stored with m_uncorr=1.

Ports:
- clk  in  1  System clock; all logic on its rising edge.
- rst_n  in  1  Reset, asynchronous, active-low.
- valid_in  in  1  Upstream word valid. No backpressure exists toward upstream.
- data_in  in  32  Corrected data from upstream.
- error_detected  in  1  Upstream ECC error flag; qualified by valid_in.
- error_corrected  in  1  Upstream single-bit-corrected flag; qualified by valid_in.
- m_valid  out  1  Head entry available.
- m_ready  in  1  Consumer accepts the head entry.
- m_data  out  32  Head entry data.
- m_corrected  out  1  Head entry was single-bit corrected.
- m_uncorr  out  1  Head entry is uncorrectable. Always 0 when DROP_UNCORR=1.
- fill_level  out  $clog2(DEPTH)+1  Current number of stored entries.
- clear_stats  in  1  Synchronous clear of counters and irq.
- corr_cnt  out  CNT_W  Corrected-word events.
- uncorr_cnt  out  CNT_W  Uncorrectable-word events.
- ovf_cnt  out  CNT_W  Words lost to a full FIFO.
- irq  out  1  Sticky: an uncorrectable or overflow event has occurred since the last clear.

## Operation
- Event decode is qualified by valid_in:
  - corr = error_corrected.
  - uncorr = error_detected & ~error_corrected.
  - error flags are ignored when valid_in=0.
- pop = m_valid & m_ready.
- want = valid_in & ~(DROP_UNCORR & uncorr).
- push = want & (~full | pop). A full FIFO accepts a write in the same cycle as a pop.
- overflow = want & full & ~pop. The word is discarded and the FIFO is unchanged.
- Each entry is stored as {data_in, corr, uncorr}.
- Storage is a register array with read and write pointers of $clog2(DEPTH) bits. Pointers wrap naturally from DEPTH-1 to 0.
- Occupancy counter (fill_level) update per cycle:
  - +1 on push without pop.
  - -1 on pop without push.
  - unchanged on both or neither.
- full = (fill_level == DEPTH); empty = (fill_level == 0).
- m_valid = ~empty.
- m_data, m_corrected and m_uncorr are read combinationally from the entry at the read pointer. They are 0 when empty.
- A pop while empty cannot occur because m_valid=0. m_ready is a don't-care when m_valid=0.
- Counters:
  - corr_cnt increments on every corr event, whether or not the word was stored or overflowed.
  - uncorr_cnt increments on every uncorr event, including dropped words.
  - ovf_cnt increments on every overflow.
  - All counters saturate at 2^CNT_W-1 and never wrap.
- irq is set by any uncorr or overflow event.
- clear_stats: counters and irq are zeroed first, then same-cycle events are applied. Result: counter = 1 for an event in the clear cycle, and irq = 1 if that event is uncorr or overflow.
- clear_stats does not affect the FIFO contents or pointers.

## Timing
- Reset value of every output is 0: m_valid, m_data, m_corrected, m_uncorr, fill_level, all counters, irq. Pointers and occupancy also reset to 0.
- Reset asserted mid-operation flushes all stored entries immediately (asynchronous).
- Latency: a word pushed at rising edge N shows m_valid=1 and its data after edge N. There is no same-cycle bypass.
- Handshake:
  - The head entry is held stable while m_valid=1 and m_ready=0.
  - Entries leave in push order.
- Throughput: one push and one pop per cycle, sustained at any occupancy, including full.
- Counter and irq updates become visible the cycle after the event edge.

## Test plan
- Reset, then 3 clean words 0x11111111, 0x22222222, 0x33333333 with m_ready=0 -> fill_level=3 and m_data=0x11111111. Then m_ready=1 -> the three words drain in order, m_valid drops after the third, and all counters stay 0.
- DEPTH=8: push 10 clean words with m_ready=0 -> fill_level=8, ovf_cnt=2, irq=1, and the 8 stored words are the first 8. Repeat with m_ready=1 in the full cycles -> no overflow.
- Word 0xDEADBEEF with error_detected=1, error_corrected=1 -> stored with m_corrected=1, corr_cnt=1, irq=0. Word with error_detected=1, error_corrected=0 under DROP_UNCORR=1 -> not stored, uncorr_cnt=1, irq=1. Under DROP_UNCORR=0 -> stored with m_uncorr=1.
- CNT_W=4: 20 corrected words -> corr_cnt holds at 15. Then clear_stats pulse coincident with a corrected word -> corr_cnt=1, and irq cleared to 0.
- FIFO holding 5 entries, rst_n pulsed low between edges -> fill_level, m_valid and irq are 0 immediately. Post-reset, the first push appears at the head.
- valid_in=0 with error_detected=1 held for 10 cycles -> no counter change and no push.
